// File: rtl/fir_stream_pipe.sv
// Streaming FIR filter: gated delay line, one registered multiplier per tap,
// registered binary adder tree. Double-buffered coefficients (shadow/active)
// allow a glitch-free swap while samples keep flowing.

// Per-tap multiplier: full-precision signed product, sign-extended to the
// accumulator width so the adder tree never needs to re-extend.
module fir_tap_prod #(
  parameter int DATA_WIDTH  = 18,
  parameter int COEFF_WIDTH = 18,
  parameter int ACC_WIDTH   = 39
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic signed [DATA_WIDTH-1:0]  tap_i,
  input  logic signed [COEFF_WIDTH-1:0] coef_i,
  output logic [ACC_WIDTH-1:0]          prod_o
);
  logic [ACC_WIDTH-1:0] prod_q;

  // Registered product; operands are sign-extended before the multiply.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prod_q <= '0;
    else          prod_q <= ACC_WIDTH'(tap_i) * ACC_WIDTH'(coef_i);
  end

  assign prod_o = prod_q;
endmodule

module fir_stream_pipe #(
  parameter int N_TAPS      = 8,
  parameter int DATA_WIDTH  = 18,
  parameter int COEFF_WIDTH = 18,
  localparam int ADDR_W     = $clog2(N_TAPS),
  localparam int ACC_WIDTH  = DATA_WIDTH + COEFF_WIDTH + $clog2(N_TAPS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   clear,
  input  logic                   coef_we,
  input  logic [ADDR_W-1:0]      coef_addr,
  input  logic [COEFF_WIDTH-1:0] coef_data,
  input  logic                   coef_commit,
  output logic                   out_valid,
  output logic [ACC_WIDTH-1:0]   data_out
);
  localparam int LVLS    = $clog2(N_TAPS);
  localparam int LEAVES  = 1 << LVLS;
  localparam int LATENCY = 2 + LVLS;

  // Index 0 is the newest sample (tap0).
  logic [N_TAPS-1:0][DATA_WIDTH-1:0]  tap_q;
  logic [N_TAPS-1:0][COEFF_WIDTH-1:0] shadow_q, shadow_d, act_q;
  // vld_pipe_q[0] = v1 (delay line), [1] = v2 (products), [LATENCY-1] = out.
  logic [LATENCY-1:0]                 vld_pipe_q;
  logic [LEAVES-1:0][ACC_WIDTH-1:0]   leaf;
  // Internal tree nodes in heap order; node 0 is the root / data_out.
  logic [LEAVES-2:0][ACC_WIDTH-1:0]   node_q;
  // Full heap view: internal nodes first, then leaves, so children of i are
  // 2i+1 and 2i+2 regardless of which kind of node they are.
  logic [2*LEAVES-2:0][ACC_WIDTH-1:0] heap;
  logic                               addr_ok;

  assign addr_ok = (ADDR_W+1)'(coef_addr) < (ADDR_W+1)'(N_TAPS);

  // Shadow bank next state; a same-cycle commit sees this merged value.
  always_comb begin
    shadow_d = shadow_q;
    if (coef_we && addr_ok) shadow_d[coef_addr] = coef_data;
  end

  // Coefficient banks; clear intentionally has no effect here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      act_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (coef_commit) act_q <= shadow_d;
    end
  end

  // Delay line shifts only on accepted samples; clear flushes and wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      tap_q <= '0;
    else if (clear)    tap_q <= '0;
    else if (in_valid) tap_q <= {tap_q[N_TAPS-2:0], data_in};
  end

  // Valid shift register tracking each sample through every stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   vld_pipe_q <= '0;
    else if (clear) vld_pipe_q <= '0;
    else            vld_pipe_q <= {vld_pipe_q[LATENCY-2:0], in_valid};
  end

  // One multiplier per real tap; padding leaves are constant zero.
  for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
    if (k < N_TAPS) begin : g_mul
      fir_tap_prod #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEFF_WIDTH(COEFF_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_prod (
        .clk    (clk),
        .reset_n(reset_n),
        .tap_i  (tap_q[k]),
        .coef_i (act_q[k]),
        .prod_o (leaf[k])
      );
    end else begin : g_pad
      assign leaf[k] = '0;
    end
  end

  assign heap = {leaf, node_q};

  // Adder tree: inner nodes free-run; the root only loads a valid result so
  // data_out holds between outputs and is untouched by clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      node_q <= '0;
    end else begin
      for (int i = 1; i < LEAVES - 1; i++)
        node_q[i] <= heap[2*i+1] + heap[2*i+2];
      if (vld_pipe_q[LVLS] && !clear)
        node_q[0] <= heap[1] + heap[2];
    end
  end

  assign data_out  = heap[0];
  assign out_valid = vld_pipe_q[LATENCY-1];
endmodule

// File: tb/tb_fir_stream_pipe.sv
// Directed bench: 4-tap instance for the main scenarios, 6-tap instance for
// the non-power-of-two tree and out-of-range coefficient writes.
module tb_fir_stream_pipe;
  localparam int L4 = 4;   // latency, 4 taps
  localparam int L6 = 5;   // latency, 6 taps

  logic clk;
  logic reset_n;

  logic        iv4, clr4, we4, cm4, ov4;
  logic [17:0] din4, cd4;
  logic [1:0]  ca4;
  logic [37:0] do4;

  logic        iv6, clr6, we6, cm6, ov6;
  logic [17:0] din6, cd6;
  logic [2:0]  ca6;
  logic [38:0] do6;

  int checks, failures, cyc;
  bit     ov4_log [0:2047];
  longint do4_log [0:2047];
  bit     ov6_log [0:2047];
  longint do6_log [0:2047];

  int gv [6] = '{1, 0, 0, 1, 1, 1};
  int gd [6] = '{1, 99, 99, 0, 0, 0};
  int ge [6] = '{10, 10, 10, 20, 30, 40};

  fir_stream_pipe #(.N_TAPS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv4), .data_in(din4), .clear(clr4),
    .coef_we(we4), .coef_addr(ca4), .coef_data(cd4), .coef_commit(cm4),
    .out_valid(ov4), .data_out(do4)
  );

  fir_stream_pipe #(.N_TAPS(6)) dut6 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv6), .data_in(din6), .clear(clr6),
    .coef_we(we6), .coef_addr(ca6), .coef_data(cd6), .coef_commit(cm6),
    .out_valid(ov6), .data_out(do6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; log both outputs as seen just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    ov4_log[cyc] = ov4;
    do4_log[cyc] = longint'($signed(do4));
    ov6_log[cyc] = ov6;
    do6_log[cyc] = longint'($signed(do6));
  endtask

  task automatic drv4(input bit v, input int d, input bit we, input int a,
                      input int cd, input bit cm, input bit cl);
    iv4 = v; din4 = 18'(d); we4 = we; ca4 = 2'(a); cd4 = 18'(cd);
    cm4 = cm; clr4 = cl;
    tick();
    iv4 = 0; we4 = 0; cm4 = 0; clr4 = 0;
  endtask

  task automatic drv6(input bit v, input int d, input bit we, input int a,
                      input int cd, input bit cm);
    iv6 = v; din6 = 18'(d); we6 = we; ca6 = 3'(a); cd6 = 18'(cd); cm6 = cm;
    tick();
    iv6 = 0; we6 = 0; cm6 = 0;
  endtask

  initial begin
    int s, cc, k;
    checks = 0; failures = 0; cyc = 0;
    iv4 = 0; clr4 = 0; we4 = 0; cm4 = 0; din4 = '0; cd4 = '0; ca4 = '0;
    iv6 = 0; clr6 = 0; we6 = 0; cm6 = 0; din6 = '0; cd6 = '0; ca6 = '0;
    reset_n = 1'b0;

    // Reset state
    #12;
    check("rst_ov4", ov4, 0);
    check("rst_do4", do4_log[0] + longint'($signed(do4)), 0);
    check("rst_ov6", ov6, 0);
    check("rst_do6", longint'($signed(do6)), 0);
    @(negedge clk) reset_n = 1'b1;

    // Impulse; last write shares the cycle with commit
    drv4(0, 0, 1, 0, 10, 0, 0);
    drv4(0, 0, 1, 1, 20, 0, 0);
    drv4(0, 0, 1, 2, 30, 0, 0);
    drv4(0, 0, 1, 3, 40, 1, 0);
    drv4(1, 1, 0, 0, 0, 0, 0); s = cyc;
    for (int i = 0; i < 3; i++) drv4(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drv4(0, 0, 0, 0, 0, 0, 0);
    check("imp_early_ov", ov4_log[s+L4-2], 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("imp_ov%0d", i), ov4_log[s+L4-1+i], 1);
      check($sformatf("imp_do%0d", i), do4_log[s+L4-1+i], 10 * (i + 1));
    end
    check("imp_late_ov", ov4_log[s+L4+3], 0);
    check("imp_hold_do", do4_log[s+L4+3], 40);

    // Gapped input: valid pattern reproduced, data held across gaps
    for (int i = 0; i < 6; i++) begin
      drv4(gv[i][0], gd[i], 0, 0, 0, 0, 0);
      if (i == 0) s = cyc;
    end
    for (int i = 0; i < 4; i++) drv4(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("gap_ov%0d", i), ov4_log[s+L4-1+i], gv[i]);
      check($sformatf("gap_do%0d", i), do4_log[s+L4-1+i], ge[i]);
    end

    // Extreme values: full-precision, no overflow; mixed-sign follow-up
    for (int i = 0; i < 4; i++) drv4(0, 0, 1, i, -131072, i == 3, 0);
    for (int i = 0; i < 5; i++) begin
      drv4(1, -131072, 0, 0, 0, 0, 0);
      if (i == 0) s = cyc;
    end
    drv4(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drv4(0, 0, 0, 0, 0, 0, 0);
    check("ext_y0", do4_log[s+L4-1], 64'sd17179869184);
    check("ext_y3", do4_log[s+L4+2], 64'sd68719476736);
    check("ext_y4", do4_log[s+L4+3], 64'sd68719476736);
    check("ext_ov5", ov4_log[s+L4+4], 1);
    check("ext_y5", do4_log[s+L4+4], 64'sd51539476480);

    // Hot swap: shadow writes are invisible until commit
    for (int i = 0; i < 4; i++) drv4(0, 0, 1, i, 10 * (i + 1), i == 3, 0);
    for (int i = 0; i < 8; i++) drv4(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drv4(1, 1, 1, i, 1, 0, 0);
    drv4(1, 1, 0, 0, 0, 1, 0); cc = cyc;
    for (int i = 0; i < 6; i++) drv4(1, 1, 0, 0, 0, 0, 0);
    check("hot_pre_commit", do4_log[cc-1], 100);
    check("hot_commit_cyc", do4_log[cc+L4-2], 100);
    check("hot_new_ov", ov4_log[cc+L4-1], 1);
    check("hot_new_bank", do4_log[cc+L4-1], 4);

    // Clear with in_valid, plus a coefficient write+commit in the same cycle
    drv4(1, 1, 1, 0, 2, 1, 1); k = cyc;
    for (int i = 0; i < 4; i++) drv4(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < L4; i++)
      check($sformatf("clr_ov%0d", i), ov4_log[k+i], 0);
    check("clr_do_hold", do4_log[k+L4-1], 4);
    drv4(1, 1, 0, 0, 0, 0, 0); s = cyc;
    for (int i = 0; i < 3; i++) drv4(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drv4(0, 0, 0, 0, 0, 0, 0);
    check("clr_imp_do0", do4_log[s+L4-1], 2);
    check("clr_imp_do1", do4_log[s+L4], 1);
    check("clr_imp_do3", do4_log[s+L4+2], 1);

    // Reset mid-stream
    for (int i = 0; i < 6; i++) drv4(1, 1, 0, 0, 0, 0, 0);
    check("pre_rst_ov", ov4_log[cyc], 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ov", ov4, 0);
    check("rst_mid_do", longint'($signed(do4)), 0);
    drv4(0, 0, 0, 0, 0, 0, 0);
    drv4(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    drv4(1, 1, 0, 0, 0, 0, 0); s = cyc;
    for (int i = 0; i < 3; i++) drv4(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drv4(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < L4 - 1; i++)
      check($sformatf("post_rst_ov%0d", i), ov4_log[s+i], 0);
    check("post_rst_first_ov", ov4_log[s+L4-1], 1);
    check("post_rst_zero_coef", do4_log[s+L4-1], 0);

    // 6 taps: padded tree, out-of-range writes ignored
    for (int i = 0; i < 6; i++) drv6(0, 0, 1, i, i + 1, i == 5);
    drv6(0, 0, 1, 7, 99, 1);
    drv6(0, 0, 1, 6, 77, 1);
    drv6(1, 1, 0, 0, 0, 0); s = cyc;
    for (int i = 0; i < 5; i++) drv6(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drv6(0, 0, 0, 0, 0, 0);
    check("t6_early_ov", ov6_log[s+L6-2], 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t6_ov%0d", i), ov6_log[s+L6-1+i], 1);
      check($sformatf("t6_do%0d", i), do6_log[s+L6-1+i], i + 1);
    end
    check("t6_late_ov", ov6_log[s+L6+5], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
